mm_uart_tx_arbiter: RTL and testbench
=====================================

# mm_uart_tx_arbiter

Shares the memory-mapped UART transmit path among `NUM_REQ` byte-stream requesters, such as the CPU store path, a debug monitor and a trace dumper. It sits between the requesters and the UART register port. For each byte it polls the TX ready register, then issues a single-cycle write to the TX data register. Grants rotate round-robin, and a requester holds its grant until it signals the last byte of a message, so messages from different requesters never interleave.

## Interface
- `NUM_REQ`, 2: number of requesters (2–8).
- `DATA_WIDTH`, 32: UART register bus width.
- `TX_ADDR`, 32'h90000020: TX data register address.
- `TX_READY_ADDR`, 32'h90000024: TX ready register address.
- `HOLD_TIMEOUT`, 1024: idle cycles allowed while a message is open before the grant is forcibly released (≥1).
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in 8*NUM_REQ: byte i is `req_data[8i+7:8i]`.
- `req_last` in NUM_REQ: the byte being offered is the last of its message.
- `req_ready` out NUM_REQ: one-hot pulse; the byte is accepted this cycle.
- `grant` out NUM_REQ: one-hot current owner; all zeros when free.
- `uart_we` out 1: write strobe to the UART port.
- `uart_addr` out DATA_WIDTH: UART register address.
- `uart_wdata` out DATA_WIDTH: write data, `{zeros, byte}`.
- `uart_rdata` in DATA_WIDTH: combinational read data from the UART port; bit 0 = TX FIFO has space.
- `busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, POLL, WRITE, HOLD.
- **IDLE**
  - All bus outputs are 0.
  - If any `req_valid` is high, pick the first requester at or after `rr_ptr` (circular order), set `grant`, go to POLL.
- **POLL**
  - Drive `uart_addr=TX_READY_ADDR`, `uart_we=0`.
  - `uart_rdata[0]=1`: go to WRITE.
  - `uart_rdata[0]=0`: stay in POLL indefinitely (no timeout while polling).
  - Granted `req_valid` low: go to IDLE, release the grant, leave `rr_ptr` unchanged, perform no write.
- **WRITE**
  - Drive `uart_addr=TX_ADDR`, `uart_we=1`, `uart_wdata[7:0]` = granted byte, upper bits 0.
  - Pulse the granted `req_ready` for exactly this cycle.
  - Granted `req_last=1`: go to IDLE, clear `grant`, set `rr_ptr=(winner+1) mod NUM_REQ`.
  - Otherwise go to HOLD and clear the timeout counter.
- **HOLD**
  - Bus outputs are 0; `grant` is retained.
  - Granted `req_valid` high: go to POLL.
  - Otherwise increment the counter; on reaching `HOLD_TIMEOUT-1`, release as in the last-byte case.
  - Other requesters are ignored while in HOLD.
- **Requester rule:** `req_data` and `req_last` stay stable while `req_valid` is high and `req_ready` has not yet pulsed.
- **Counter width:** `$clog2(HOLD_TIMEOUT+1)`; the counter saturates and never wraps.
- **Reset asserted (`reset=0`):**
  - State IDLE, `rr_ptr=0`, counter 0.
  - All outputs 0 immediately; no partial write survives.
  - Reset can assert in any state, including mid-WRITE; the interrupted byte is lost and not retried.

## Timing
- Requester sees `req_ready` in the same cycle as `uart_we`.
- First byte, TX ready:
  - `req_valid` rises at edge 0; IDLE samples it.
  - POLL runs in cycle 1, WRITE in cycle 2 (`uart_we` high 1 cycle).
  - Latency is 2 cycles.
- Back-to-back bytes within a message take 3 cycles each: WRITE, then HOLD, then POLL (with valid already high in HOLD).
- TX FIFO full: each extra POLL cycle adds 1 cycle of latency.
- Simultaneous valids in IDLE: `rr_ptr` decides the winner. After the winner's last byte, the next requester in circular order wins the next arbitration.
- Only one `uart_we` per WRITE; never two consecutive `uart_we` cycles.

## Test plan
- **Reset values:** reset low for 3 cycles, then release with no requests → all outputs 0, `busy=0`, state IDLE.
- **Single byte:** req0 sends 0x41 with last, ready bit=1 → `uart_we` at cycle 2, `uart_addr=32'h90000020`, `uart_wdata=32'h41`, `req_ready=2'b01` the same cycle, grant cleared at cycle 3.
- **Contention:** req0 and req1 both valid with 3-byte messages "ABC" and "xyz" → write order A,B,C,x,y,z; the next simultaneous request grants req0 (pointer rotated past req1).
- **Backpressure:** ready bit held 0 for 20 cycles → stays in POLL, no `uart_we`; write occurs 1 cycle after the ready bit goes to 1.
- **Hold timeout:** `HOLD_TIMEOUT=8`, req1 sends a byte without last, then idles while req0 waits → req1's grant released after 8 HOLD cycles, req0 granted the next cycle.
- **Reset mid-WRITE:** reset asserted during a WRITE cycle → `uart_we` drops asynchronously; after release, a fresh request restarts at IDLE with `rr_ptr=0`.

Source files
------------

// File: rtl/mm_uart_tx_arbiter.sv
// Round-robin arbiter that shares a memory-mapped UART TX port among
// byte-stream requesters, holding the grant for a whole message.
module mm_uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] TX_ADDR = 32'h90000020,
    parameter logic [DATA_WIDTH-1:0] TX_READY_ADDR = 32'h90000024,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [8*NUM_REQ-1:0]    req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    uart_we,
    output logic [DATA_WIDTH-1:0]   uart_addr,
    output logic [DATA_WIDTH-1:0]   uart_wdata,
    input  logic [DATA_WIDTH-1:0]   uart_rdata,
    output logic                    busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        POLL,
        WRITE,
        HOLD
    } state_t;

    state_t              state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       pick;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       next_ptr;
    logic [NUM_REQ-1:0]  pick_oh;
    logic                found;
    logic [CW-1:0]       hold_cnt;
    logic                last_q;
    logic                own_valid;
    logic                own_last;
    logic [7:0]          own_data;
    logic                tx_space;
    logic                rdata_unused;

    assign tx_space = uart_rdata[0];
    assign rdata_unused = ^uart_rdata[DATA_WIDTH-1:1];
    assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_comb begin : owner_mux
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
            end
        end
    end

    // First valid requester at or after rr_ptr, in circular order.
    always_comb begin : rr_pick
        pick  = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pick_oh[i] = (pick == IW'(i));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            hold_cnt   <= '0;
            last_q     <= 1'b0;
            grant      <= '0;
            req_ready  <= '0;
            uart_we    <= 1'b0;
            uart_addr  <= '0;
            uart_wdata <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state     <= POLL;
                        owner     <= pick;
                        grant     <= pick_oh;
                        busy      <= 1'b1;
                        uart_addr <= TX_READY_ADDR;
                    end
                end
                POLL: begin
                    if (!own_valid) begin
                        state     <= IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                        uart_addr <= '0;
                    end else if (tx_space) begin
                        state      <= WRITE;
                        last_q     <= own_last;
                        uart_we    <= 1'b1;
                        uart_addr  <= TX_ADDR;
                        uart_wdata <= DATA_WIDTH'(own_data);
                        req_ready  <= grant;
                    end
                end
                WRITE: begin
                    uart_we    <= 1'b0;
                    uart_addr  <= '0;
                    uart_wdata <= '0;
                    req_ready  <= '0;
                    hold_cnt   <= '0;
                    if (last_q) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (own_valid) begin
                        state     <= POLL;
                        uart_addr <= TX_READY_ADDR;
                    end else if (hold_cnt >= HOLD_LAST) begin
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_uart_tx_arbiter.sv
// Bench for mm_uart_tx_arbiter: directed scenarios plus randomized
// traffic checked against a cycle model and per-requester byte queues.
module tb_mm_uart_tx_arbiter;

    localparam int N = 2;
    localparam int DW = 32;
    localparam int HT = 8;
    localparam logic [31:0] TXA = 32'h90000020;
    localparam logic [31:0] RDA = 32'h90000024;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           uart_we;
    logic [DW-1:0]  uart_addr;
    logic [DW-1:0]  uart_wdata;
    logic [DW-1:0]  uart_rdata = '0;
    logic           busy;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mm_uart_tx_arbiter #(
        .NUM_REQ(N),
        .DATA_WIDTH(DW),
        .TX_ADDR(TXA),
        .TX_READY_ADDR(RDA),
        .HOLD_TIMEOUT(HT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .uart_we(uart_we),
        .uart_addr(uart_addr),
        .uart_wdata(uart_wdata),
        .uart_rdata(uart_rdata),
        .busy(busy)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: who owns the port, whether it is polling or writing,
    // the pending byte and the idle-cycle count of an open message.
    int         m_owner = -1;
    int         m_ptr = 0;
    int         m_idle = 0;
    bit         m_poll = 0;
    bit         m_write = 0;
    logic [7:0] m_byte = '0;
    bit         m_lastb = 0;

    task automatic m_release();
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
    endtask

    task automatic model_step();
        int w;
        if (m_write) begin
            m_write = 0;
            if (m_lastb) m_release();
            else m_idle = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (req_valid[w]) begin
                    m_owner = w;
                    m_poll = 1;
                    break;
                end
            end
        end else if (m_poll) begin
            if (!req_valid[m_owner]) begin
                m_owner = -1;
                m_poll = 0;
            end else if (uart_rdata[0]) begin
                m_poll = 0;
                m_write = 1;
                m_byte = req_data[8*m_owner +: 8];
                m_lastb = req_last[m_owner];
            end
        end else begin
            if (req_valid[m_owner]) m_poll = 1;
            else if (m_idle == HT - 1) m_release();
            else m_idle++;
        end
    endtask

    task automatic model_check();
        logic [N-1:0]  eg;
        logic [DW-1:0] ea;
        logic [DW-1:0] ed;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        ea = m_write ? TXA : (m_poll ? RDA : 32'h0);
        ed = m_write ? {24'h0, m_byte} : 32'h0;
        chk("model_cmp",
            {uart_we, uart_addr, uart_wdata, req_ready, grant, busy},
            {m_write, ea, ed, (m_write ? eg : 2'b00), eg,
             (m_owner >= 0)});
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            m_owner = -1;
            m_ptr = 0;
            m_idle = 0;
            m_poll = 0;
            m_write = 0;
        end else begin
            model_step();
        end
        #1;
        model_check();
    end

    // Requester and UART-side drivers.
    logic [7:0] q_d[N][$];
    bit         q_l[N][$];
    logic [N-1:0] rdy_prev = '0;
    int space_mode = 1;
    int gate_pct = 100;
    int wlog[$];
    int n_pushed = 0;
    int n_written = 0;

    task automatic push(input int r, input logic [7:0] d, input bit l);
        q_d[r].push_back(d);
        q_l[r].push_back(l);
        n_pushed++;
    endtask

    task automatic drive();
        int wi;
        logic [8:0] he;
        for (int i = 0; i < N; i++) begin
            if (rdy_prev[i] && q_d[i].size() > 0) begin
                void'(q_d[i].pop_front());
                void'(q_l[i].pop_front());
            end
        end
        if (uart_we) begin
            wi = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) wi = i;
            he = (q_d[wi].size() > 0) ? {1'b1, q_d[wi][0]} : 9'h0;
            chk("head_byte", {1'b1, uart_wdata[7:0]}, he);
            wlog.push_back(wi * 256 + int'(uart_wdata[7:0]));
            n_written++;
        end
        rdy_prev = req_ready;
        for (int i = 0; i < N; i++) begin
            if (q_d[i].size() > 0) begin
                req_valid[i] = ($urandom_range(0, 99) < gate_pct);
                req_data[8*i +: 8] = q_d[i][0];
                req_last[i] = q_l[i][0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'h0;
                req_last[i] = 1'b0;
            end
        end
        case (space_mode)
            0: uart_rdata = 32'h0;
            1: uart_rdata = 32'h1;
            default: uart_rdata = {31'h0, ($urandom_range(0, 3) != 0)};
        endcase
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        step();
        drive();
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            q_d[i].delete();
            q_l[i].delete();
        end
        rdy_prev = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush();
        drive();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic run_drain(input int max);
        int c;
        c = 0;
        while ((q_d[0].size() > 0 || q_d[1].size() > 0 || busy)
               && c < max) begin
            tick();
            c++;
        end
        chk("drain_bound", (c < max), 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hold;
        bit saw_we;
        int exp_log[6];

        // Reset values
        reset = 1'b0;
        drive();
        repeat (3) step();
        chk("reset_outs",
            {uart_we, uart_addr, uart_wdata, req_ready, grant, busy}, '0);
        reset = 1'b1;
        tick();
        tick();
        chk("idle_outs",
            {uart_we, uart_addr, uart_wdata, req_ready, grant, busy}, '0);

        // Single byte
        do_reset();
        space_mode = 1;
        push(0, 8'h41, 1);
        drive();
        tick();
        chk("single_poll", {uart_we, uart_addr, grant, busy},
            {1'b0, RDA, 2'b01, 1'b1});
        tick();
        chk("single_write", {uart_we, uart_addr, uart_wdata, req_ready},
            {1'b1, TXA, 32'h41, 2'b01});
        tick();
        chk("single_release", {uart_we, grant, busy}, '0);

        // Contention
        do_reset();
        wlog.delete();
        push(0, "A", 0); push(0, "B", 0); push(0, "C", 1);
        push(1, "x", 0); push(1, "y", 0); push(1, "z", 1);
        drive();
        run_drain(200);
        exp_log = '{65, 66, 67, 256 + 120, 256 + 121, 256 + 122};
        chk("contention_len", wlog.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("contention_order%0d", i),
                (i < wlog.size()) ? wlog[i] : -1, exp_log[i]);
        end
        push(0, 8'h50, 1);
        push(1, 8'h51, 1);
        drive();
        tick();
        chk("contention_rotate", grant, 2'b01);
        run_drain(100);

        // Backpressure
        do_reset();
        space_mode = 0;
        push(0, 8'h55, 1);
        drive();
        tick();
        saw_we = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw_we |= uart_we;
        end
        chk("bp_no_we", {saw_we, uart_addr, busy}, {1'b0, RDA, 1'b1});
        space_mode = 1;
        uart_rdata = 32'h1;
        tick();
        chk("bp_write", {uart_we, uart_wdata}, {1'b1, 32'h55});
        run_drain(20);

        // Hold timeout
        do_reset();
        push(1, 8'h31, 0);
        drive();
        c = 0;
        do begin
            tick();
            c++;
        end while (!uart_we && c < 10);
        chk("hold_first_we", {uart_we, req_ready}, {1'b1, 2'b10});
        push(0, 8'h30, 1);
        hold = 0;
        c = 0;
        tick();
        while (grant == 2'b10 && c < 30) begin
            hold++;
            tick();
            c++;
        end
        chk("hold_cycles", hold, HT);
        chk("hold_released", grant, 2'b00);
        tick();
        chk("hold_next_grant", grant, 2'b01);
        flush();
        drive();
        run_drain(50);

        // Reset mid-WRITE
        do_reset();
        push(0, 8'h10, 1);
        drive();
        run_drain(20);
        push(0, 8'h11, 1);
        push(1, 8'h22, 1);
        drive();
        c = 0;
        do begin
            tick();
            c++;
        end while (!uart_we && c < 10);
        chk("mid_write_owner", {uart_we, req_ready}, {1'b1, 2'b10});
        #2;
        reset = 1'b0;
        #1;
        chk("mid_write_clear",
            {uart_we, uart_addr, req_ready, grant, busy}, '0);
        flush();
        drive();
        step();
        step();
        reset = 1'b1;
        push(0, 8'h33, 1);
        push(1, 8'h44, 1);
        drive();
        tick();
        chk("mid_write_ptr0", grant, 2'b01);
        run_drain(50);

        // Randomized traffic
        do_reset();
        n_pushed = 0;
        n_written = 0;
        space_mode = 2;
        gate_pct = 90;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int r = 0; r < N; r++) begin
                if (q_d[r].size() == 0 && $urandom_range(0, 9) == 0) begin
                    c = $urandom_range(1, 4);
                    for (int b = 0; b < c; b++) begin
                        push(r, 8'($urandom), (b == c - 1));
                    end
                end
            end
            tick();
        end
        gate_pct = 100;
        run_drain(500);
        tick();
        chk("random_bytes", n_written, n_pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
